idea_decrypt_iter: RTL and testbench

- Iterative IDEA decryption core; the inverse of the team's combinational `encrypt` block.
- Expands a 128-bit user key into the 52 encryption subkeys and derives the 52 decryption subkeys using on-chip multiplicative and additive inverses.
- Processes one round per clock, so ciphertext out of `encrypt` returns as the original plaintext.
- Sits on the receive side of the datapath, behind a valid/ready stream.

---
 rtl/idea_decrypt_iter.sv | 215 +++++++++++++++++++++
 tb/tb_idea_decrypt_iter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/idea_decrypt_iter.sv
// Iterative IDEA decryption: key expansion, on-chip subkey inversion, then one round per clock.
// state  | meaning
// IDLE   | no valid subkeys, waiting for a key
// KEYGEN | 7 cycles writing 8 encryption subkeys per cycle
// INVERT | 18 sequential inverses (30 cycles each) plus negations and copies
// READY  | decryption subkeys valid, waiting for a ciphertext block
// ROUND  | 8 cycles, one IDEA round per cycle
// FINAL  | output transform, result registered
module idea_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic [63:0]  in,
  output logic         in_ready,
  output logic         out_valid,
  output logic [63:0]  out,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_KEYGEN, S_INVERT, S_READY, S_ROUND, S_FINAL} state_t;

  // Multiply mod 65537 with 0 standing for 65536.
  function automatic logic [15:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] lo, hi;
    p  = a * b;
    lo = p[15:0];
    hi = p[31:16];
    if (a == 16'd0)      mul16 = 16'd1 - b;
    else if (b == 16'd0) mul16 = 16'd1 - a;
    else                 mul16 = lo - hi + {15'd0, lo < hi};
  endfunction

  function automatic logic [63:0] idea_round(input logic [63:0] x,
                                             input logic [15:0] k0, input logic [15:0] k1,
                                             input logic [15:0] k2, input logic [15:0] k3,
                                             input logic [15:0] k4, input logic [15:0] k5,
                                             input logic swap);
    logic [15:0] a, b, c, d, t2, t4, t5;
    a  = mul16(x[63:48], k0);
    b  = x[47:32] + k1;
    c  = x[31:16] + k2;
    d  = mul16(x[15:0], k3);
    t2 = mul16(a ^ c, k4);
    t4 = mul16((b ^ d) + t2, k5);
    t5 = t2 + t4;
    if (swap) idea_round = {a ^ t4, c ^ t4, b ^ t5, d ^ t5};
    else      idea_round = {a ^ t4, b ^ t5, c ^ t4, d ^ t5};
  endfunction

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [4:0]   slot_q, slot_d;
  logic [127:0] kreg_q, kreg_d;
  logic [15:0]  z_q [52];
  logic [15:0]  z_d [52];
  logic [15:0]  dk_q [52];
  logic [15:0]  dk_d [52];
  logic [15:0]  acc_q, acc_d;
  logic [63:0]  blk_q, blk_d;
  logic [63:0]  out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         key_ready_q, key_ready_d;
  logic         busy_q, busy_d;
  logic         keys_ok_q, keys_ok_d;

  logic         key_accept, in_accept;
  logic [5:0]   kg_base, kg_idx;
  logic [5:0]   inv_r6, inv_zi, inv_di;
  logic [15:0]  inv_x, inv_a, inv_prod;
  logic         inv_swap;
  logic [2:0]   rnd_r;
  logic [5:0]   rnd_base;
  logic [63:0]  rnd_out, fin_out;

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign in_ready   = (state_q == S_READY) && keys_ok_q && !key_valid && (!out_valid_q || out_ready);
  assign key_accept = key_valid && key_ready_q;
  assign in_accept  = in_valid && in_ready;

  // Slot s inverts Z[48-6r(+3)] into DK[6r(+3)], r = s/2; slots 16/17 land on the output transform.
  assign inv_r6   = {2'b00, slot_q[4:1]};
  assign inv_zi   = 6'd48 - 6'd6 * inv_r6 + {4'b0000, slot_q[0], slot_q[0]};
  assign inv_di   = 6'd6 * inv_r6 + {4'b0000, slot_q[0], slot_q[0]};
  assign inv_x    = z_q[inv_zi];
  assign inv_a    = (cnt_q == 5'd29) ? inv_x : acc_q;
  assign inv_prod = cnt_q[0] ? mul16(inv_a, inv_a) : mul16(acc_q, inv_x);
  assign inv_swap = (inv_r6 != 6'd0) && (inv_r6 != 6'd8);

  assign kg_base  = {3'(5'd6 - cnt_q), 3'b000};
  assign rnd_r    = 3'(5'd7 - cnt_q);
  assign rnd_base = 6'd6 * {3'b000, rnd_r};
  assign rnd_out  = idea_round(blk_q, dk_q[rnd_base], dk_q[rnd_base + 6'd1], dk_q[rnd_base + 6'd2],
                               dk_q[rnd_base + 6'd3], dk_q[rnd_base + 6'd4], dk_q[rnd_base + 6'd5],
                               cnt_q != 5'd0);
  assign fin_out  = {mul16(blk_q[63:48], dk_q[48]), blk_q[47:32] + dk_q[49],
                     blk_q[31:16] + dk_q[50], mul16(blk_q[15:0], dk_q[51])};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    kreg_d      = kreg_q;
    z_d         = z_q;
    dk_d        = dk_q;
    acc_d       = acc_q;
    blk_d       = blk_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    keys_ok_d   = keys_ok_q;
    kg_idx      = '0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (key_accept) begin
      state_d   = S_KEYGEN;
      kreg_d    = key;
      cnt_d     = 5'd6;
      keys_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_KEYGEN: begin
          for (int i = 0; i < 8; i++) begin
            kg_idx = kg_base + 6'(i);
            if (kg_idx < 6'd52) z_d[kg_idx] = kreg_q[127-16*i -: 16];
          end
          kreg_d = {kreg_q[102:0], kreg_q[127:103]};
          if (cnt_q == 5'd0) begin
            state_d = S_INVERT;
            slot_d  = 5'd0;
            cnt_d   = 5'd29;
          end else cnt_d = cnt_q - 5'd1;
        end
        S_INVERT: begin
          acc_d = inv_prod;
          if (cnt_q == 5'd0) begin
            dk_d[inv_di] = inv_prod;
            if (!slot_q[0]) begin
              dk_d[inv_di + 6'd1] = 16'd0 - z_q[inv_swap ? inv_zi + 6'd2 : inv_zi + 6'd1];
              dk_d[inv_di + 6'd2] = 16'd0 - z_q[inv_swap ? inv_zi + 6'd1 : inv_zi + 6'd2];
              if (inv_r6 != 6'd8) begin
                dk_d[inv_di + 6'd4] = z_q[inv_zi - 6'd2];
                dk_d[inv_di + 6'd5] = z_q[inv_zi - 6'd1];
              end
            end
            if (slot_q == 5'd17) begin
              state_d   = S_READY;
              keys_ok_d = 1'b1;
            end else begin
              slot_d = slot_q + 5'd1;
              cnt_d  = 5'd29;
            end
          end else cnt_d = cnt_q - 5'd1;
        end
        S_READY: begin
          if (in_accept) begin
            state_d = S_ROUND;
            blk_d   = in;
            cnt_d   = 5'd7;
          end
        end
        S_ROUND: begin
          blk_d = rnd_out;
          if (cnt_q == 5'd0) state_d = S_FINAL;
          else cnt_d = cnt_q - 5'd1;
        end
        S_FINAL: begin
          out_d       = fin_out;
          out_valid_d = 1'b1;
          state_d     = S_READY;
        end
        default: ;
      endcase
    end
    key_ready_d = (state_d == S_IDLE) || (state_d == S_READY);
    busy_d      = !key_ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      keys_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      keys_ok_q   <= keys_ok_d;
    end
  end

  // Datapath storage needs no reset; the control state gates its use.
  always_ff @(posedge clk) begin
    kreg_q <= kreg_d;
    z_q    <= z_d;
    dk_q   <= dk_d;
    acc_q  <= acc_d;
    blk_q  <= blk_d;
  end

endmodule

// File: tb/tb_idea_decrypt_iter.sv
// Scoreboarded bench for idea_decrypt_iter; ciphertexts come from a reference IDEA encryptor.
module tb_idea_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n, key_valid, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] key;
  logic [63:0]  din, dout;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  localparam logic [127:0] KEY_STD = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] KEY_B   = 128'h2BD6_459F_82C5_B300_952C_4910_4881_FF48;
  localparam logic [127:0] KEY_C   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;

  idea_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key), .key_ready(key_ready),
    .in_valid(in_valid), .in(din), .in_ready(in_ready), .out_valid(out_valid), .out(dout),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    longint unsigned aa, bb, p;
    aa = (a == 16'd0) ? 64'd65536 : 64'(a);
    bb = (b == 16'd0) ? 64'd65536 : 64'(b);
    p  = (aa * bb) % 64'd65537;
    return (p == 64'd65536) ? 16'd0 : p[15:0];
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] pt, input logic [127:0] k);
    logic [15:0] z [52];
    logic [127:0] kk;
    logic [15:0] x1, x2, x3, x4, a, b, c, d, t2, t4, t5;
    kk = k;
    for (int g = 0; g < 7; g++) begin
      for (int i = 0; i < 8; i++)
        if (8*g + i < 52) z[8*g + i] = kk[127-16*i -: 16];
      kk = {kk[102:0], kk[127:103]};
    end
    {x1, x2, x3, x4} = pt;
    for (int r = 0; r < 8; r++) begin
      a  = m_mul(x1, z[6*r]);
      b  = x2 + z[6*r+1];
      c  = x3 + z[6*r+2];
      d  = m_mul(x4, z[6*r+3]);
      t2 = m_mul(a ^ c, z[6*r+4]);
      t4 = m_mul(16'((b ^ d) + t2), z[6*r+5]);
      t5 = t2 + t4;
      x1 = a ^ t4;
      x4 = d ^ t5;
      if (r < 7) begin x2 = c ^ t4; x3 = b ^ t5; end
      else       begin x2 = b ^ t5; x3 = c ^ t4; end
    end
    return {m_mul(x1, z[48]), 16'(x2 + z[49]), 16'(x3 + z[50]), m_mul(x4, z[51])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare on every output handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("out_unexpected", dout, 64'hx);
      else check("out_data", dout, sb.pop_front());
    end
  end

  task automatic load_key(input logic [127:0] k);
    int n, irdy;
    @(negedge clk);
    key_valid = 1'b1;
    key = k;
    #1;
    n = 0;
    while (!key_ready && n < 2000) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    irdy = 0;
    while (!key_ready && n < 1000) begin
      if (in_ready) irdy++;
      @(negedge clk);
      n++;
    end
    check("key_load_cycles", 64'(n), 64'd547);
    check("in_ready_during_keyload", 64'(irdy), 64'd0);
  endtask

  task automatic send_block(input logic [63:0] ct, input logic [63:0] pt, input bit check_lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    din = ct;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin
      check("in_ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(pt);
    @(negedge clk);
    in_valid = 1'b0;
    if (check_lat) begin
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      check("latency", 64'(n), 64'd9);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0;
    key = '0;
    in_valid = 1'b0;
    din = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", dout, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_key_ready", 64'(key_ready), 64'd1);
    rst_n = 1'b1;

    // Published vector; Z[0]=1 so DK[48]=inv(1)=1 is exercised.
    load_key(KEY_STD);
    send_block(64'h11FB_ED2B_0198_6DE5, 64'h0000_0001_0002_0003, 1'b1);
    wait_drain();

    load_key(128'd1);
    send_block(m_enc(64'd3, 128'd1), 64'd3, 1'b1);
    wait_drain();

    // All-zero key: every inverse is inv(0).
    load_key(128'd0);
    send_block(m_enc(64'd0, 128'd0), 64'd0, 1'b1);
    wait_drain();

    // Backpressure: hold the result, then consume and accept in one cycle.
    out_ready = 1'b0;
    send_block(m_enc(64'h0123_4567_89AB_CDEF, 128'd0), 64'h0123_4567_89AB_CDEF, 1'b1);
    in_valid = 1'b1;
    din = m_enc(64'hFFFF_0000_FFFF_0001, 128'd0);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("bp_out_stable", dout, 64'h0123_4567_89AB_CDEF);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(64'hFFFF_0000_FFFF_0001);
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();

    // Reset during INVERT.
    @(negedge clk);
    key_valid = 1'b1;
    key = KEY_B;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (100) @(negedge clk);
    reset_check("rst_invert");
    load_key(KEY_B);
    send_block(m_enc(64'h5555_AAAA_1234_8001, KEY_B), 64'h5555_AAAA_1234_8001, 1'b1);
    wait_drain();

    // Reset landing on round 4.
    send_block(m_enc(64'h0BAD_F00D_0000_FFFF, KEY_B), 64'h0BAD_F00D_0000_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    reset_check("rst_round");
    load_key(KEY_STD);
    send_block(64'h11FB_ED2B_0198_6DE5, 64'h0000_0001_0002_0003, 1'b1);
    wait_drain();

    // Rekey from READY.
    load_key(KEY_C);
    send_block(m_enc(64'h0000_0001_0002_0003, KEY_C), 64'h0000_0001_0002_0003, 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
